// File: rtl/multi_sprite_bouncer.sv
// multi_sprite_bouncer
//   Moves N_SPR rectangular sprites around the visible frame. Each sprite bounces
//   off the frame edges on its own. Once per frame, on the rising edge of vsync, a
//   small state machine updates one sprite per clock. Every pixel shows the
//   highest-priority sprite over a gradient background. Priority goes to the
//   lowest index. The output is registered.
//
// Ports
//   clk_pix, rst_pix      pixel clock; asynchronous active-high reset
//   sx, sy, de            current pixel coordinate and visible-area enable
//   vsync, pause          frame tick (rising edge used); motion freeze
//   pix_r/g/b             4-bit colour, one clk_pix after sx/sy/de
//   hit_valid, hit_id     a sprite covers the pixel / index of that sprite
//   frame_done            one-cycle pulse after the last sprite is updated
//   overrun               sticky: a vsync edge arrived while an update was running
module multi_sprite_bouncer #(
  parameter int CORDW = 10,
  parameter int N_SPR = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SPR_W = 64,
  parameter int SPR_H = 48,
  parameter int GAP   = 8
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             vsync,
  input  logic             pause,
  output logic [3:0]       pix_r,
  output logic [3:0]       pix_g,
  output logic [3:0]       pix_b,
  output logic             hit_valid,
  output logic [2:0]       hit_id,
  output logic             frame_done,
  output logic             overrun
);

  localparam int PW = CORDW + 2;
  localparam int KW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  typedef logic signed [PW-1:0] pos_t;
  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam pos_t           X_MAX = pos_t'(H_RES - SPR_W);
  localparam pos_t           Y_MAX = pos_t'(V_RES - SPR_H);
  localparam logic [CORDW:0] W_EXT = (CORDW + 1)'(SPR_W);
  localparam logic [CORDW:0] H_EXT = (CORDW + 1)'(SPR_H);

  // The staggered start positions must all fit inside the frame.
  if (N_SPR < 1 || N_SPR > 8 ||
      (N_SPR - 1) * (SPR_W + GAP) > H_RES - SPR_W ||
      (N_SPR - 1) * (SPR_H + GAP) > V_RES - SPR_H) begin : g_param_check
    $error("multi_sprite_bouncer: sprite layout does not fit the frame");
  end

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic          vsync_prev_q;
  logic          frame_done_q;
  logic          overrun_q;
  pos_t          x_q     [N_SPR];
  pos_t          y_q     [N_SPR];
  logic          dir_x_q [N_SPR];
  logic          dir_y_q [N_SPR];

  logic vs_edge;
  assign vs_edge = vsync & ~vsync_prev_q;

  // Next position for sprite k. Only one sprite is in flight per cycle.
  pos_t spd_x, spd_y, nx, ny, x_d, y_d;
  logic dir_x_d, dir_y_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    spd_x   = pos_t'(1 + (int'(k_q) % 4));
    spd_y   = pos_t'(1 + ((int'(k_q) + 2) % 4));
    nx      = dir_x_q[k_q] ? x_q[k_q] + spd_x : x_q[k_q] - spd_x;
    ny      = dir_y_q[k_q] ? y_q[k_q] + spd_y : y_q[k_q] - spd_y;
    x_d     = nx;
    y_d     = ny;
    dir_x_d = dir_x_q[k_q];
    dir_y_d = dir_y_q[k_q];
    // Clamp and reverse only on overshoot. An exact wall touch reverses next frame.
    if (nx < 0) begin
      x_d = '0;    dir_x_d = 1'b1;
    end else if (nx > X_MAX) begin
      x_d = X_MAX; dir_x_d = 1'b0;
    end
    if (ny < 0) begin
      y_d = '0;    dir_y_d = 1'b1;
    end else if (ny > Y_MAX) begin
      y_d = Y_MAX; dir_y_d = 1'b0;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      vsync_prev_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      // NOTE: the sprite arrays are reset on purpose; their reset value is the start layout.
      for (int i = 0; i < N_SPR; i++) begin
        x_q[i]     <= pos_t'(i * (SPR_W + GAP));
        y_q[i]     <= pos_t'(i * (SPR_H + GAP));
        dir_x_q[i] <= ~i[0];
        dir_y_q[i] <= 1'b1;
      end
    end else begin
      // NOTE: all state uses non-blocking assignment, so reads see the pre-edge values.
      vsync_prev_q <= vsync;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (vs_edge && !pause) begin
            k_q     <= '0;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          x_q[k_q]     <= x_d;
          y_q[k_q]     <= y_d;
          dir_x_q[k_q] <= dir_x_d;
          dir_y_q[k_q] <= dir_y_d;
          if (k_q == KW'(N_SPR - 1)) state_q <= S_DONE;
          else                       k_q     <= k_q + KW'(1);
          if (vs_edge) overrun_q <= 1'b1;
        end
        S_DONE: begin
          frame_done_q <= 1'b1;
          state_q      <= S_IDLE;
          if (vs_edge) overrun_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pixel compositing. Scanning from the highest index down lets the lowest index win.
  // Positions are never negative, so the low CORDW+1 bits compare as unsigned.
  logic           hit_c;
  logic [2:0]     id_c;
  logic [3:0]     r_c, g_c, b_c;
  logic [CORDW:0] sx_e, sy_e;

  assign sx_e = {1'b0, sx};
  assign sy_e = {1'b0, sy};

  always_comb begin
    hit_c = 1'b0;
    id_c  = '0;
    r_c   = sx[7:4];
    g_c   = sy[7:4];
    b_c   = 4'h4;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (sx_e >= x_q[i][CORDW:0] && sx_e < x_q[i][CORDW:0] + W_EXT &&
          sy_e >= y_q[i][CORDW:0] && sy_e < y_q[i][CORDW:0] + H_EXT) begin
        hit_c = 1'b1;
        id_c  = 3'(i);
        r_c   = 4'hF;
        g_c   = 4'(5 * i);
        b_c   = 4'(15 - 3 * i);
      end
    end
  end

  logic [3:0] pix_r_q, pix_g_q, pix_b_q;
  logic       hit_valid_q;
  logic [2:0] hit_id_q;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      pix_r_q     <= '0;
      pix_g_q     <= '0;
      pix_b_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_id_q    <= '0;
    end else if (de) begin
      pix_r_q     <= r_c;
      pix_g_q     <= g_c;
      pix_b_q     <= b_c;
      hit_valid_q <= hit_c;
      hit_id_q    <= id_c;
    end else begin
      pix_r_q     <= '0;
      pix_g_q     <= '0;
      pix_b_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_id_q    <= '0;
    end
  end

  assign pix_r      = pix_r_q;
  assign pix_g      = pix_g_q;
  assign pix_b      = pix_b_q;
  assign hit_valid  = hit_valid_q;
  assign hit_id     = hit_id_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_multi_sprite_bouncer.sv
// Testbench for multi_sprite_bouncer (default parameters). A behavioural model
// tracks every sprite's position and direction frame by frame. Pixel probes at
// each sprite's corners, at overlaps and at random points compare the registered
// colour, hit flag and id against the model's composite.
module tb_multi_sprite_bouncer;

  localparam int N  = 4;
  localparam int HR = 640;
  localparam int VR = 480;
  localparam int W  = 64;
  localparam int H  = 48;
  localparam int G  = 8;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic [9:0] sx, sy;
  logic       de, vsync, pause;
  logic [3:0] pix_r, pix_g, pix_b;
  logic       hit_valid;
  logic [2:0] hit_id;
  logic       frame_done, overrun;

  multi_sprite_bouncer dut (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .sx        (sx),
    .sy        (sy),
    .de        (de),
    .vsync     (vsync),
    .pause     (pause),
    .pix_r     (pix_r),
    .pix_g     (pix_g),
    .pix_b     (pix_b),
    .hit_valid (hit_valid),
    .hit_id    (hit_id),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk_pix = ~clk_pix;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mx [N];
  int my [N];
  int mdx[N];
  int mdy[N];
  bit movr;

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      mx[i]  = i * (W + G);
      my[i]  = i * (H + G);
      mdx[i] = (i % 2 == 0) ? 1 : 0;
      mdy[i] = 1;
    end
    movr = 1'b0;
  endtask

  task automatic model_step();
    int n;
    for (int i = 0; i < N; i++) begin
      n = (mdx[i] != 0) ? mx[i] + (1 + i % 4) : mx[i] - (1 + i % 4);
      if (n < 0)           begin mx[i] = 0;      mdx[i] = 1; end
      else if (n > HR - W) begin mx[i] = HR - W; mdx[i] = 0; end
      else                       mx[i] = n;
      n = (mdy[i] != 0) ? my[i] + (1 + (i + 2) % 4) : my[i] - (1 + (i + 2) % 4);
      if (n < 0)           begin my[i] = 0;      mdy[i] = 1; end
      else if (n > VR - H) begin my[i] = VR - H; mdy[i] = 0; end
      else                       my[i] = n;
    end
  endtask

  task automatic model_pix(input int px, input int py, input bit pde,
                           output logic [3:0] r, output logic [3:0] g, output logic [3:0] b,
                           output logic hv, output logic [2:0] id);
    r = 4'h0; g = 4'h0; b = 4'h0; hv = 1'b0; id = 3'd0;
    if (pde) begin
      r = px[7:4];
      g = py[7:4];
      b = 4'h4;
      for (int i = 0; i < N; i++) begin
        if (!hv && px >= mx[i] && px < mx[i] + W && py >= my[i] && py < my[i] + H) begin
          hv = 1'b1;
          id = 3'(i);
          r  = 4'hF;
          g  = 4'((5 * i) % 16);
          b  = 4'((((15 - 3 * i) % 16) + 16) % 16);
        end
      end
    end
  endtask

  task automatic probe(input int px, input int py, input bit pde, input string name);
    logic [3:0] er, eg, eb;
    logic       ehv;
    logic [2:0] eid;
    @(negedge clk_pix);
    sx = 10'(px);
    sy = 10'(py);
    de = pde;
    @(negedge clk_pix);
    model_pix(px, py, pde, er, eg, eb, ehv, eid);
    checks++;
    if ({pix_r, pix_g, pix_b, hit_valid, hit_id} !== {er, eg, eb, ehv, eid}) begin
      errors++;
      $display("FAIL %s pixel(%0d,%0d,de=%0b): got rgb=%h%h%h hit=%b id=%0d, expected rgb=%h%h%h hit=%b id=%0d",
               name, px, py, pde, pix_r, pix_g, pix_b, hit_valid, hit_id, er, eg, eb, ehv, eid);
    end
    de = 1'b0;
  endtask

  // Probes each sprite's top-left pixel and the pixels just outside it, then any
  // overlap corner so that priority is exercised.
  task automatic check_positions(input string name);
    int ox, oy;
    for (int i = 0; i < N; i++) begin
      probe(mx[i], my[i], 1'b1, name);
      if (mx[i] > 0) probe(mx[i] - 1, my[i], 1'b1, name);
      if (my[i] > 0) probe(mx[i], my[i] - 1, 1'b1, name);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        ox = (mx[i] > mx[j]) ? mx[i] : mx[j];
        oy = (my[i] > my[j]) ? my[i] : my[j];
        if (ox < mx[i] + W && ox < mx[j] + W && oy < my[i] + H && oy < my[j] + H)
          probe(ox, oy, 1'b1, {name, "_overlap"});
      end
    end
  endtask

  // One vsync rising edge. frame_done is checked on every cycle of a fixed window.
  // With second_edge set, another edge lands two cycles later, during the update.
  task automatic send_edge(input bit p, input bit second_edge, input string name);
    repeat ($urandom_range(0, 3)) @(negedge clk_pix);
    @(negedge clk_pix);
    pause = p;
    vsync = 1'b1;
    for (int n = 0; n <= N + 3; n++) begin
      @(negedge clk_pix);
      if (n == 0) vsync = 1'b0;
      if (second_edge && n == 1) vsync = 1'b1;
      if (second_edge && n == 2) vsync = 1'b0;
      checks++;
      if (frame_done !== 1'(!p && n == N + 1)) begin
        errors++;
        $display("FAIL %s frame_done %0d cycles after edge: got %b expected %b",
                 name, n, frame_done, !p && n == N + 1);
      end
    end
    pause = 1'b0;
    if (!p) model_step();
    if (second_edge && !p) movr = 1'b1;
    checks++;
    if (overrun !== movr) begin
      errors++;
      $display("FAIL %s overrun: got %b expected %b", name, overrun, movr);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({pix_r, pix_g, pix_b, hit_valid, hit_id, frame_done, overrun} !== 19'd0) begin
      errors++;
      $display("FAIL %s reset outputs: got rgb=%h%h%h hit=%b id=%0d fd=%b ovr=%b expected all zero",
               name, pix_r, pix_g, pix_b, hit_valid, hit_id, frame_done, overrun);
    end
  endtask

  task automatic test_reset();
    check_outputs_zero("reset");
    @(negedge clk_pix);
    rst_pix = 1'b0;
    model_init();
    probe(0, 0, 1'b1, "reset_origin");
    probe(0, 0, 1'b0, "de_low");
    probe(HR - 1, VR - 1, 1'b1, "background_corner");
    check_positions("reset_layout");
  endtask

  task automatic test_first_frame();
    send_edge(1'b0, 1'b0, "first_frame");
    check_positions("first_frame");
  endtask

  // Long enough for every sprite to hit walls, including sprite 0 at the right edge.
  task automatic test_bounce();
    bit p;
    for (int f = 0; f < 720; f++) begin
      p = ($urandom_range(0, 7) == 0);
      send_edge(p, 1'b0, "bounce");
      check_positions("bounce");
      probe($urandom_range(0, HR - 1), $urandom_range(0, VR - 1), 1'b1, "random_pixel");
      probe($urandom_range(0, HR - 1), $urandom_range(0, VR - 1), ($urandom_range(0, 3) != 0),
            "random_pixel");
    end
  endtask

  task automatic test_pause();
    for (int e = 0; e < 3; e++) send_edge(1'b1, 1'b0, "pause");
    check_positions("pause");
  endtask

  task automatic test_overrun();
    send_edge(1'b0, 1'b1, "overrun");
    check_positions("overrun");
    send_edge(1'b0, 1'b0, "overrun_sticky");
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk_pix);
    vsync = 1'b1;
    @(negedge clk_pix);
    vsync = 1'b0;
    repeat (2) @(negedge clk_pix);
    rst_pix = 1'b1;
    #1;
    check_outputs_zero("reset_mid_update");
    @(negedge clk_pix);
    rst_pix = 1'b0;
    model_init();
    for (int n = 0; n < N + 4; n++) begin
      @(negedge clk_pix);
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_update frame_done after reset: got %b expected 0", frame_done);
      end
    end
    check_positions("reset_mid_update");
    send_edge(1'b0, 1'b0, "after_reset");
    check_positions("after_reset");
  endtask

  initial begin
    rst_pix = 1'b1;
    sx = '0;
    sy = '0;
    de = 1'b0;
    vsync = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk_pix);
    test_reset();
    test_first_frame();
    test_bounce();
    test_pause();
    test_overrun();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
